ps2_led_transmitter: RTL

// Host-to-device PS/2 transmitter. Sends the keyboard "Set LEDs" command (0xED, then LED byte),
// so the keyboard lock LEDs mirror the Volume/Pitch/Distortion effect switches.

---
 rtl/ps2_led_transmitter.sv | 333 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_led_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_led_transmitter
//
// Host-to-device PS/2 transmitter. Sends the keyboard "Set LEDs" command
// (0xED followed by the LED byte) so the keyboard lock LEDs track the
// Volume / Pitch / Distortion effect switches. It shares PS2_CLK / PS2_DAT
// with the PS/2 receiver and uses the receiver's decoded bytes to see the
// keyboard's 0xFA acknowledge.
//
// Parameters
//   INHIBIT_CYCLES  clocks PS2_CLK is held low to request the bus
//   TIMEOUT_CYCLES  max clocks between device clock edges, or before 0xFA
//   RETRY_MAX       whole-command retries before error is flagged
//
// Ports
//   Clock            in     system clock
//   Resetn           in     asynchronous, active-low reset
//   led_bits[2:0]    in     [0]=Scroll(Volume) [1]=Num(Pitch) [2]=Caps(Distortion)
//   send_req         in     one-cycle request, taken only while busy=0
//   ps2_key_data[7:0]in     byte decoded by the PS/2 receiver
//   ps2_key_pressed  in     one-cycle strobe, ps2_key_data valid
//   PS2_CLK          inout  open-drain clock (driven 0 or released)
//   PS2_DAT          inout  open-drain data  (driven 0 or released)
//   busy             out    command in progress
//   tx_active        out    this block owns the bus; receiver must ignore it
//   done             out    one-cycle pulse, both bytes acknowledged
//   error            out    one-cycle pulse, all retries used up
//   led_state[2:0]   out    led_bits of the last successful command
// ---------------------------------------------------------------------------
module ps2_led_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RETRY_MAX      = 3
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [2:0] led_bits,
    input  logic       send_req,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       tx_active,
    output logic       done,
    output logic       error,
    output logic [2:0] led_state
);

    localparam int INH_W   = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [INH_W-1:0]   INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] REPLY_ACK    = 8'hFA;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SHIFT,
        S_ACKBIT,
        S_LINEIDLE,
        S_WAIT_FA,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]         clk_sync;
    logic [1:0]         dat_sync;
    logic               clk_prev;
    logic               clk_s;
    logic               dat_s;
    logic               clk_fall;

    logic [INH_W-1:0]   inhibit_cnt;
    logic [TO_W-1:0]    timeout_cnt;
    logic               timed_out;
    logic [3:0]         edge_cnt;
    logic [RETRY_W-1:0] retry_cnt;

    logic [7:0]         tx_byte;
    logic               parity_bit;
    logic [2:0]         led_latched;

    logic               clk_low;
    logic               dat_low;
    logic               clk_low_next;
    logic               dat_low_next;

    logic               accept;
    logic               load_led_byte;
    logic               retry_inc;
    logic               commit;

    // The pins are open-drain: a register only ever pulls them to 0 or
    // lets go. Both drive registers clear asynchronously, so a reset frees
    // the bus in the same cycle.
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign clk_s      = clk_sync[1];
    assign dat_s      = dat_sync[1];
    assign clk_fall   = clk_prev & ~clk_s;
    assign timed_out  = (timeout_cnt == TO_LAST);
    assign parity_bit = ~^tx_byte;

    // Two-flop synchronisers on both bus lines, plus a delayed copy of the
    // synced clock so a device falling edge shows up as a single-cycle
    // strobe. They idle high to match a released bus.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_s;
        end
    end

    // State register and the registered pin drivers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            clk_low <= 1'b0;
            dat_low <= 1'b0;
        end else begin
            state   <= state_next;
            clk_low <= clk_low_next;
            dat_low <= dat_low_next;
        end
    end

    // Inhibit length counter. It sits at zero outside S_INHIBIT, so every
    // entry into S_INHIBIT starts a fresh full-length hold.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            inhibit_cnt <= '0;
        end else if (state == S_INHIBIT) begin
            inhibit_cnt <= inhibit_cnt + 1'b1;
        end else begin
            inhibit_cnt <= '0;
        end
    end

    // Watchdog between device clock edges. It restarts on every synced
    // falling edge and on every state change, and saturates so it cannot
    // wrap back to a small value while the block sits idle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            timeout_cnt <= '0;
        end else if ((state_next != state) || clk_fall) begin
            timeout_cnt <= '0;
        end else if (!timed_out) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Counts device falling edges within one frame: edges 1..10 move the
    // data, parity and stop bits, edge 11 carries the device ACK bit.
    // It is capped at 11.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            edge_cnt <= 4'd0;
        end else if (state == S_RELEASE) begin
            edge_cnt <= 4'd0;
        end else if (clk_fall && ((state == S_SHIFT) || (state == S_ACKBIT))
                     && (edge_cnt != 4'd11)) begin
            edge_cnt <= edge_cnt + 4'd1;
        end
    end

    // Command datapath: which byte is on the wire, the LED bits captured at
    // request time, the retry count, and the LED state reported after a
    // fully acknowledged command.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tx_byte     <= 8'h00;
            led_latched <= 3'b000;
            retry_cnt   <= '0;
            led_state   <= 3'b000;
        end else begin
            if (accept) begin
                led_latched <= led_bits;
                tx_byte     <= CMD_SET_LEDS;
                retry_cnt   <= '0;
            end else if (load_led_byte) begin
                tx_byte <= {5'b00000, led_latched};
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
                tx_byte   <= CMD_SET_LEDS;
            end
            if (commit) begin
                led_state <= led_latched;
            end
        end
    end

    // Next-state and output decode. The pin-drive values computed here are
    // registered, so the pins follow the state by one clock: PS2_CLK is low
    // for exactly INHIBIT_CYCLES clocks, and PS2_DAT goes low during the
    // last of them so the start bit is already present when the clock is
    // released.
    always_comb begin
        state_next    = state;
        clk_low_next  = 1'b0;
        dat_low_next  = 1'b0;
        accept        = 1'b0;
        load_led_byte = 1'b0;
        retry_inc     = 1'b0;
        commit        = 1'b0;
        busy          = 1'b1;
        tx_active     = 1'b0;
        done          = 1'b0;
        error         = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (send_req) begin
                    accept     = 1'b1;
                    state_next = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                tx_active    = 1'b1;
                clk_low_next = 1'b1;
                if (inhibit_cnt == INH_LAST) begin
                    dat_low_next = 1'b1;
                    state_next   = S_RELEASE;
                end
            end

            S_RELEASE: begin
                tx_active    = 1'b1;
                dat_low_next = 1'b1;
                state_next   = S_SHIFT;
            end

            // Data only changes on a device falling edge; the device samples
            // on the following rising edge. A 0 bit pulls the line low, a 1
            // bit releases it.
            S_SHIFT: begin
                tx_active    = 1'b1;
                dat_low_next = dat_low;
                if (clk_fall) begin
                    case (edge_cnt)
                        4'd0, 4'd1, 4'd2, 4'd3,
                        4'd4, 4'd5, 4'd6, 4'd7: dat_low_next = ~tx_byte[edge_cnt[2:0]];
                        4'd8:                   dat_low_next = ~parity_bit;
                        default: begin
                            dat_low_next = 1'b0;
                            state_next   = S_ACKBIT;
                        end
                    endcase
                end else if (timed_out) begin
                    state_next = S_FAIL;
                end
            end

            S_ACKBIT: begin
                tx_active = 1'b1;
                if (clk_fall) begin
                    state_next = dat_s ? S_FAIL : S_LINEIDLE;
                end else if (timed_out) begin
                    state_next = S_FAIL;
                end
            end

            S_LINEIDLE: begin
                tx_active = 1'b1;
                if (clk_s && dat_s) begin
                    state_next = S_WAIT_FA;
                end else if (timed_out) begin
                    state_next = S_FAIL;
                end
            end

            // The bus is handed back so the receiver can decode the reply.
            S_WAIT_FA: begin
                if (ps2_key_pressed) begin
                    if (ps2_key_data == REPLY_ACK) begin
                        if (tx_byte == CMD_SET_LEDS) begin
                            load_led_byte = 1'b1;
                            state_next    = S_INHIBIT;
                        end else begin
                            state_next = S_DONE;
                        end
                    end else begin
                        state_next = S_FAIL;
                    end
                end else if (timed_out) begin
                    state_next = S_FAIL;
                end
            end

            S_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                commit     = 1'b1;
                state_next = S_IDLE;
            end

            // Any failure restarts the whole command from 0xED.
            S_FAIL: begin
                if (retry_cnt < RETRY_LIM) begin
                    retry_inc  = 1'b1;
                    state_next = S_INHIBIT;
                end else begin
                    busy       = 1'b0;
                    error      = 1'b1;
                    state_next = S_IDLE;
                end
            end

            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
